// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache answering the
// MEM-stage request port. Read hits are served combinationally in IDLE;
// read misses and all writes go to a fixed-latency backing store and stall
// the pipeline through BUSY.
module dcache_responder #(
  parameter int LINES     = 16,
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        BUSY
);

  localparam int IW = $clog2(LINES);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int TW = AW - IW;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q;
  logic            op_rd_q;
  logic [AW-1:0]   word_q;
  logic [31:0]     wdata_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     fill_q;
  logic [LINES-1:0] valid_q;

  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES];
  logic [31:0]     mem_q  [MEM_WORDS];

  // Request decode on the live inputs
  logic [AW-1:0]   in_word;
  logic [IW-1:0]   in_idx;
  logic [TW-1:0]   in_tag;
  logic            req_rd;
  logic            req_wr;
  logic            hit;

  assign in_word = Addr[2+AW-1:2];
  assign in_idx  = in_word[IW-1:0];
  assign in_tag  = in_word[AW-1:IW];
  assign req_rd  = (MEM == 2'b10);
  assign req_wr  = (MEM == 2'b01);
  assign hit     = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  // Fields of the captured request
  logic [IW-1:0]   cap_idx;
  logic [TW-1:0]   cap_tag;
  logic            complete;
  logic            cap_line_hit;

  assign cap_idx      = word_q[IW-1:0];
  assign cap_tag      = word_q[AW-1:IW];
  assign complete     = (state_q == S_WAIT) && (cnt_q == '0);
  assign cap_line_hit = valid_q[cap_idx] && (tag_q[cap_idx] == cap_tag);

  // Address bits outside the word address are deliberately ignored
  logic unused_addr;
  assign unused_addr = ^{Addr[31:2+AW], Addr[1:0]};

  // Stall and read-data outputs; forced quiet while reset is held
  always_comb begin
    BUSY  = 1'b0;
    Rdata = '0;
    if (rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_rd && hit) begin
            Rdata = data_q[in_idx];
          end else if (req_rd || req_wr) begin
            BUSY = 1'b1;
          end
        end
        S_WAIT: BUSY = 1'b1;
        S_RESP: Rdata = op_rd_q ? fill_q : '0;
        default: ;
      endcase
    end
  end

  // Control FSM, request capture, latency counter, fill register, valid bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_rd_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      valid_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if ((req_rd && !hit) || req_wr) begin
            op_rd_q <= req_rd;
            word_q  <= in_word;
            wdata_q <= Wdata;
            cnt_q   <= CW'(LAT - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (op_rd_q) begin
              fill_q           <= mem_q[word_q];
              valid_q[cap_idx] <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays: filled on read completion, refreshed on a write hit.
  // Kept out of the reset block; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (complete) begin
      if (op_rd_q) begin
        tag_q[cap_idx]  <= cap_tag;
        data_q[cap_idx] <= mem_q[word_q];
      end else if (cap_line_hit) begin
        data_q[cap_idx] <= wdata_q;
      end
    end
  end

  // Backing store: written only at the completing edge, so a reset during
  // WAIT drops the pending write
  always_ff @(posedge clk) begin
    if (complete && !op_rd_q) begin
      mem_q[word_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder (LINES=16, MEM_WORDS=1024, LAT=4).
module tb_dcache_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  MEM;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        BUSY;

  int n_vec;
  int n_err;

  dcache_responder #(
    .LINES    (16),
    .MEM_WORDS(1024),
    .LAT      (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .MEM  (MEM),
    .Addr (Addr),
    .Wdata(Wdata),
    .Rdata(Rdata),
    .BUSY (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request, count busy cycles (scrambling Addr/Wdata while
  // stalled), then check the busy count and the response data.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_busy, input bit chk_data, input logic [31:0] exp_rd,
                        input string name);
    int nb;
    MEM   = op;
    Addr  = a;
    Wdata = wd;
    nb    = 0;
    @(negedge clk);
    while (BUSY && nb < 50) begin
      nb++;
      @(posedge clk);
      #1;
      Addr  = $urandom;
      Wdata = $urandom;
      @(negedge clk);
    end
    check({name, "_busy"}, 32'(nb), 32'(exp_busy));
    if (chk_data) check({name, "_rdata"}, Rdata, exp_rd);
    @(posedge clk);
    #1;
    MEM   = 2'b00;
    Addr  = '0;
    Wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    MEM   = 2'b00;
    Addr  = '0;
    Wdata = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_rdata", Rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", 32'(BUSY), 32'd0);
    check("post_rst_rdata", Rdata, 32'h0);

    // MEM=11 is no request
    MEM  = 2'b11;
    Addr = 32'h100;
    @(negedge clk);
    check("nop11_busy", 32'(BUSY), 32'd0);
    check("nop11_rdata", Rdata, 32'h0);
    @(posedge clk);
    #1;
    MEM = 2'b00;

    // Cold read miss (backing contents undefined: only the stall is checked)
    do_req(2'b10, 32'h40, 32'h0, 5, 1'b0, 32'h0, "cold_rd40");

    // Write then read miss then read hit
    do_req(2'b01, 32'h100, 32'hDEADBEEF, 5, 1'b1, 32'h0, "wr100");
    do_req(2'b10, 32'h100, 32'h0, 5, 1'b1, 32'hDEADBEEF, "rd100_miss");
    do_req(2'b10, 32'h100, 32'h0, 0, 1'b1, 32'hDEADBEEF, "rd100_hit");

    // Write hit updates the line
    do_req(2'b01, 32'h100, 32'h12345678, 5, 1'b1, 32'h0, "wr100_hit");
    do_req(2'b10, 32'h100, 32'h0, 0, 1'b1, 32'h12345678, "rd100_upd");

    // Write miss to a conflicting address does not allocate
    do_req(2'b01, 32'h140, 32'hCAFEF00D, 5, 1'b1, 32'h0, "wr140");
    do_req(2'b10, 32'h100, 32'h0, 0, 1'b1, 32'h12345678, "rd100_noalloc");

    // Conflict eviction on index 0
    do_req(2'b10, 32'h140, 32'h0, 5, 1'b1, 32'hCAFEF00D, "rd140_miss");
    do_req(2'b10, 32'h140, 32'h0, 0, 1'b1, 32'hCAFEF00D, "rd140_hit");
    do_req(2'b10, 32'h100, 32'h0, 5, 1'b1, 32'h12345678, "rd100_evicted");

    // Word-address wrap: 0x1000 aliases 0x0000
    do_req(2'b01, 32'h1000, 32'hA5A5A5A5, 5, 1'b1, 32'h0, "wr1000");
    do_req(2'b10, 32'h0000, 32'h0, 5, 1'b1, 32'hA5A5A5A5, "rd0000_wrap");
    do_req(2'b10, 32'h1000, 32'h0, 0, 1'b1, 32'hA5A5A5A5, "rd1000_alias_hit");
    // Low address bits ignored
    do_req(2'b10, 32'h0003, 32'h0, 0, 1'b1, 32'hA5A5A5A5, "rd0003_hit");

    // Reset in the middle of WAIT drops the backing write
    do_req(2'b01, 32'h200, 32'h0, 5, 1'b1, 32'h0, "wr200_zero");
    MEM   = 2'b01;
    Addr  = 32'h200;
    Wdata = 32'h55;
    @(negedge clk);
    check("midrst_busy1", 32'(BUSY), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_busy2", 32'(BUSY), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy_now", 32'(BUSY), 32'd0);
    check("midrst_rdata_now", Rdata, 32'h0);
    MEM   = 2'b00;
    Addr  = '0;
    Wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rel_busy", 32'(BUSY), 32'd0);
    do_req(2'b10, 32'h200, 32'h0, 5, 1'b1, 32'h0, "rd200_dropped");
    // Valid bits were cleared by reset
    do_req(2'b10, 32'h100, 32'h0, 5, 1'b1, 32'h12345678, "rd100_after_rst");
    do_req(2'b10, 32'h100, 32'h0, 0, 1'b1, 32'h12345678, "rd100_rehit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-through, no-write-allocate data cache that serves as the responder for the MEM-stage request interface (`MEM`/`Addr`/`Wdata` in, `Rdata`/`BUSY` out). It sits behind the memory stage, between the EX/MEM and MEM/WB latches, and stalls the pipeline through `BUSY`. Read hits complete with zero stall. Read misses and all writes go to an internal backing store with fixed latency `LAT`.

## Interface
- `LINES`, 16: cache lines, one 32-bit word each; power of 2, ≥2.
- `MEM_WORDS`, 1024: backing-store depth in words; power of 2, > `LINES`.
- `LAT`, 4: backing-store access latency in cycles; ≥1.

- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `MEM`, input, 2: request code; 2'b10 = read, 2'b01 = write, 2'b00 and 2'b11 = no request.
- `Addr`, input, 32: byte address. Bits [1:0] are ignored.
- `Wdata`, input, 32: write data.
- `Rdata`, output, 32: read data, valid in the cycle `BUSY`=0 for a read request.
- `BUSY`, output, 1: stall request to the pipeline controller.

## Operation
- Address split: IW=log2(`LINES`), AW=log2(`MEM_WORDS`).
  - index = `Addr[2+IW-1:2]`.
  - tag = `Addr[2+AW-1:2+IW]`.
  - word address = `Addr[2+AW-1:2]`.
  - `Addr` bits above 2+AW-1 are ignored, so higher addresses wrap.
- Storage: per line, a valid bit, a tag and a data word. Plus the backing array. The backing array is not reset and its contents are undefined until written.
- FSM states:
  - IDLE
    - Read hit (valid and tag match): `BUSY`=0, `Rdata`=line data, stay in IDLE.
    - Read miss or any write: `BUSY`=1. Capture op, word address, index, tag and `Wdata`. Load cnt=`LAT`-1. Go to WAIT.
    - No request: `BUSY`=0, `Rdata`=0.
  - WAIT
    - `BUSY`=1. If cnt≠0, decrement.
    - If cnt=0, perform the backing operation at this edge, then go to RESP.
      - Read: fetch backing[word]; fill the line (valid=1, tag, data); set fill register.
      - Write: write backing[word]. If the line is valid with a matching tag, update its data. Otherwise leave the line untouched.
  - RESP
    - `BUSY`=0 for exactly one cycle.
    - `Rdata`=fill register for a read; 0 for a write.
    - Go to IDLE. Any new request is not examined until IDLE.
- The requester holds `MEM`/`Addr`/`Wdata` stable while `BUSY`=1. The block uses the captured values, so changes while busy have no effect on the operation in flight.
- A request still present in the RESP cycle is not restarted. The pipeline advances on that edge because `BUSY`=0.

## Timing
- `BUSY` and `Rdata` are combinational from state, captured registers, the array and the inputs (IDLE hit path).
- Read hit: 0 stall cycles; data valid in the same cycle.
- Read miss or write: `BUSY` is high for 1+`LAT` cycles (detect cycle plus `LAT` WAIT cycles), then one RESP cycle with `BUSY`=0.
- Back-to-back: a request presented in the cycle after RESP is evaluated in IDLE normally.
- Reset (asserted at any time, including mid-WAIT):
  - State→IDLE; all valid bits cleared; cnt=0; fill register=0.
  - A pending backing write is dropped, since backing writes occur only at the completing edge.
  - Outputs `BUSY`=0, `Rdata`=0 while reset is asserted and after release until a request arrives.
- Simultaneous events: a write and a read to the same line cannot overlap (single outstanding request).

## Test plan
- Reset: assert `rst`=0 for 3 cycles, release with `MEM`=00 → `BUSY`=0, `Rdata`=0. A read of 0x40 then misses (`BUSY` high for 5 cycles with `LAT`=4).
- Write-then-read miss: write 0xDEADBEEF to 0x100 → `BUSY`=1 for 5 cycles, RESP `Rdata`=0. Read 0x100 → 5 busy cycles, then `Rdata`=0xDEADBEEF. A second read of 0x100 → `BUSY`=0, `Rdata`=0xDEADBEEF in the same cycle.
- Write hit update: with 0x100 cached, write 0x12345678 to 0x100 → 5 busy cycles. An immediate read of 0x100 hits with 0x12345678.
- Conflict eviction (`LINES`=16): cache 0x100, then read 0x140 (same index, different tag) → miss. A re-read of 0x100 → miss, returns the correct data.
- Wrap-around: write 0xA5A5A5A5 to 0x1000 (`MEM_WORDS`=1024) → a read of 0x0000 returns 0xA5A5A5A5.
- Reset mid-WAIT: write 0x55 to 0x200, assert reset after 2 busy cycles → `BUSY`=0 at once. A later read of 0x200 misses and does not return 0x55 (backing write was dropped; prior value written 0x0 before the test).
